// File: rtl/bus_sync_ram.sv
// Single-clock synchronous RAM with a request/ready handshake, per-byte write
// masking, a fixed two-cycle read latency and a hardware fill sequencer that
// writes FILL_VALUE to every word after reset or on a clear request.
module bus_sync_ram #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 11,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_mask,
    input  logic                    bus_enable,
    input  logic                    write_enable,
    input  logic                    clear,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    ready,
    output logic                    busy_clear
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        FILL   = 3'd0,
        IDLE   = 3'd1,
        WRITE  = 3'd2,
        READ_1 = 3'd3,
        READ_2 = 3'd4
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   fill_addr;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_data;
    logic [NBYTES-1:0]       req_mask;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [NBYTES-1:0]       mem_be;

    // Control FSM: fill sequencing, request acceptance and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= FILL;
            fill_addr  <= '0;
            ready      <= 1'b0;
            busy_clear <= 1'b1;
            data_out   <= '0;
        end else begin
            case (state)
                FILL: begin
                    fill_addr <= fill_addr + 1'b1;
                    if (fill_addr == '1) begin
                        state      <= IDLE;
                        ready      <= 1'b1;
                        busy_clear <= 1'b0;
                    end
                end
                IDLE: begin
                    if (clear) begin
                        state      <= FILL;
                        fill_addr  <= '0;
                        ready      <= 1'b0;
                        busy_clear <= 1'b1;
                    end else if (bus_enable) begin
                        req_addr <= address;
                        req_data <= data_in;
                        req_mask <= byte_mask;
                        ready    <= 1'b0;
                        state    <= write_enable ? WRITE : READ_1;
                    end
                end
                WRITE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                READ_1: begin
                    state <= READ_2;
                end
                READ_2: begin
                    data_out <= rd_word;
                    ready    <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    ready      <= 1'b1;
                    busy_clear <= 1'b0;
                end
            endcase
        end
    end

    // Single write port shared by the fill sequencer and the write path;
    // gated by reset so an uncommitted write is dropped on the reset edge
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = req_addr;
        mem_wdata = req_data;
        mem_be    = req_mask;
        if (reset) begin
            case (state)
                FILL: begin
                    mem_we    = 1'b1;
                    mem_addr  = fill_addr;
                    mem_wdata = FILL_VALUE;
                    mem_be    = '1;
                end
                WRITE: begin
                    mem_we = 1'b1;
                end
                default: begin
                    mem_we = 1'b0;
                end
            endcase
        end
    end

    // One byte-wide array per lane keeps byte enables a plain per-lane write
    // strobe, which maps directly onto block RAM byte-write enables
    for (genvar b = 0; b < NBYTES; b++) begin : g_lane
        logic [7:0] lane [DEPTH];
        logic [7:0] rd_byte;

        // Lane write port
        always_ff @(posedge clk) begin
            if (mem_we && mem_be[b]) begin
                lane[mem_addr] <= mem_wdata[b*8 +: 8];
            end
        end

        // Lane registered read port, captured in the first read cycle
        always_ff @(posedge clk) begin
            if (state == READ_1) begin
                rd_byte <= lane[req_addr];
            end
        end

        assign rd_word[b*8 +: 8] = rd_byte;
    end

endmodule

// File: tb/tb_bus_sync_ram.sv
// Self-checking bench for bus_sync_ram: a transaction-level model (countdown
// to ready plus a pending-operation record) checked every cycle, directed
// literal checks, randomized traffic, and a 32-bit/8-word second instance.
module tb_bus_sync_ram;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic            reset;
    logic [AW-1:0]   address;
    logic [DW-1:0]   data_in;
    logic [1:0]      byte_mask;
    logic            bus_enable;
    logic            write_enable;
    logic            clear;
    logic [DW-1:0]   data_out;
    logic            ready;
    logic            busy_clear;

    // 32-bit instance signals
    logic            p_reset;
    logic [2:0]      p_address;
    logic [31:0]     p_data_in;
    logic [3:0]      p_byte_mask;
    logic            p_bus_enable;
    logic            p_write_enable;
    logic            p_clear;
    logic [31:0]     p_data_out;
    logic            p_ready;
    logic            p_busy_clear;

    bus_sync_ram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .FILL_VALUE(16'hffff)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in),
        .byte_mask(byte_mask), .bus_enable(bus_enable), .write_enable(write_enable),
        .clear(clear), .data_out(data_out), .ready(ready), .busy_clear(busy_clear)
    );

    bus_sync_ram #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(3),
        .FILL_VALUE(32'h0)
    ) dut32 (
        .clk(clk), .reset(p_reset), .address(p_address), .data_in(p_data_in),
        .byte_mask(p_byte_mask), .bus_enable(p_bus_enable), .write_enable(p_write_enable),
        .clear(p_clear), .data_out(p_data_out), .ready(p_ready), .busy_clear(p_busy_clear)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_valid = 1'b0;
    int            m_wait  = 0;      // cycles until ready returns
    int            pend_kind = 0;    // 0 fill, 1 write, 2 read
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;
    logic [1:0]    pend_mask;
    logic          m_ready;
    logic          m_busy;
    logic [DW-1:0] m_dout;

    task automatic model_fill();
        foreach (m_mem[i]) m_mem[i] = 16'hffff;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset === 1'b0) begin
                m_valid   = 1'b1;
                m_wait    = DEPTH;
                pend_kind = 0;
                m_ready   = 1'b0;
                m_busy    = 1'b1;
                m_dout    = '0;
                model_fill();
            end else if (m_valid) begin
                if (m_wait > 0) begin
                    m_wait--;
                    if (m_wait == 0) begin
                        if (pend_kind == 1) begin
                            for (int b = 0; b < 2; b++)
                                if (pend_mask[b]) m_mem[pend_addr][b*8 +: 8] = pend_data[b*8 +: 8];
                        end else if (pend_kind == 2) begin
                            m_dout = m_mem[pend_addr];
                        end
                        m_ready = 1'b1;
                        m_busy  = 1'b0;
                    end
                end else if (clear) begin
                    m_wait    = DEPTH;
                    pend_kind = 0;
                    m_ready   = 1'b0;
                    m_busy    = 1'b1;
                    model_fill();
                end else if (bus_enable) begin
                    pend_kind = write_enable ? 1 : 2;
                    pend_addr = address;
                    pend_data = data_in;
                    pend_mask = byte_mask;
                    m_wait    = write_enable ? 1 : 2;
                    m_ready   = 1'b0;
                end
            end
        end
    end

    // Per-cycle compare of the main instance against the model
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("ready", 32'(ready), 32'(m_ready));
                check("busy_clear", 32'(busy_clear), 32'(m_busy));
                check("data_out", 32'(data_out), 32'(m_dout));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=%b required 1 within 100 cycles", ready);
        end
    endtask

    // Presents one request once ready is seen; returns at the negedge after acceptance
    task automatic req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [1:0] m);
        wait_ready();
        bus_enable   = 1'b1;
        write_enable = we;
        address      = a;
        data_in      = d;
        byte_mask    = m;
        @(negedge clk);
        bus_enable = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
        req(1'b0, a, '0, 2'b00);
        @(negedge clk);
        @(negedge clk);
        d = data_out;
    endtask

    logic [DW-1:0] rdata;
    int n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; address = '0; data_in = '0; byte_mask = '0;
        bus_enable = 1'b0; write_enable = 1'b0; clear = 1'b0;
        p_reset = 1'b0; p_address = '0; p_data_in = '0; p_byte_mask = '0;
        p_bus_enable = 1'b0; p_write_enable = 1'b0; p_clear = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy_clear", 32'(busy_clear), 32'd1);
        check("rst_data_out", 32'(data_out), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // fill lasts exactly DEPTH cycles
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("fill_cycles", 32'(n), 32'd16);

        rd(4'd0, rdata);  check("fill_rd0", 32'(rdata), 32'h0000ffff);
        rd(4'd7, rdata);  check("fill_rd7", 32'(rdata), 32'h0000ffff);
        rd(4'd15, rdata); check("fill_rd15", 32'(rdata), 32'h0000ffff);

        // write latency then read latency
        req(1'b1, 4'd5, 16'h1234, 2'b11);
        check("wr_ready_T", 32'(ready), 32'd0);
        @(negedge clk);
        check("wr_ready_T1", 32'(ready), 32'd1);
        req(1'b0, 4'd5, '0, 2'b00);
        @(negedge clk);
        check("rd_ready_T1", 32'(ready), 32'd0);
        @(negedge clk);
        check("rd_ready_T2", 32'(ready), 32'd1);
        check("rd5", 32'(data_out), 32'h00001234);

        // byte masks
        req(1'b1, 4'd3, 16'h00ab, 2'b01);
        rd(4'd3, rdata);
        check("mask01", 32'(rdata), 32'h0000ffab);
        check("model_mask01", 32'(m_mem[3]), 32'h0000ffab);
        req(1'b1, 4'd3, 16'h1111, 2'b00);
        rd(4'd3, rdata);
        check("mask00", 32'(rdata), 32'h0000ffab);

        // continuous bus_enable during a read
        req(1'b1, 4'd2, 16'h2222, 2'b11);
        req(1'b1, 4'd6, 16'h6666, 2'b11);
        wait_ready();
        bus_enable = 1'b1; write_enable = 1'b0; address = 4'd2;
        @(negedge clk);
        address = 4'd6;
        @(negedge clk);
        check("hs_busy", 32'(ready), 32'd0);
        @(negedge clk);
        check("hs_first", 32'(data_out), 32'h00002222);
        @(negedge clk);
        bus_enable = 1'b0;
        check("hs_second_accepted", 32'(ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("hs_second", 32'(data_out), 32'h00006666);
        check("hs_second_ready", 32'(ready), 32'd1);

        // clear has priority over a simultaneous request
        wait_ready();
        clear = 1'b1; bus_enable = 1'b1; write_enable = 1'b1;
        address = 4'd5; data_in = 16'h5555; byte_mask = 2'b11;
        @(negedge clk);
        clear = 1'b0; bus_enable = 1'b0;
        check("clr_busy", 32'(busy_clear), 32'd1);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("clr_cycles", 32'(n), 32'd16);
        rd(4'd5, rdata); check("clr_rd5", 32'(rdata), 32'h0000ffff);
        rd(4'd3, rdata); check("clr_rd3", 32'(rdata), 32'h0000ffff);

        // reset right after a write is accepted
        req(1'b1, 4'd9, 16'h0909, 2'b11);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrst_busy", 32'(busy_clear), 32'd1);
        check("midrst_dout", 32'(data_out), 32'd0);
        wait_ready();
        rd(4'd9, rdata); check("midrst_rd9", 32'(rdata), 32'h0000ffff);

        // randomized traffic checked by the model
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                wait_ready();
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
            end else if (r < 10) begin
                repeat (int'($urandom_range(1, 3))) @(negedge clk);
            end else begin
                req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    16'($urandom), 2'($urandom_range(0, 3)));
                if ($urandom_range(0, 3) == 0) begin
                    bus_enable   = 1'b1;
                    write_enable = 1'($urandom_range(0, 1));
                    address      = 4'($urandom_range(0, 15));
                    data_in      = 16'($urandom);
                    @(negedge clk);
                    bus_enable = 1'b0;
                end
            end
        end
        wait_ready();

        // 32-bit, 8-word instance with FILL_VALUE 0
        p_reset = 1'b0;
        repeat (2) @(negedge clk);
        p_reset = 1'b1;
        n = 0;
        while (p_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("p_fill_cycles", 32'(n), 32'd8);
        p_bus_enable = 1'b1; p_write_enable = 1'b1; p_address = 3'd1;
        p_data_in = 32'hdeadbeef; p_byte_mask = 4'b1010;
        @(negedge clk);
        p_bus_enable = 1'b0;
        check("p_wr_ready_T", 32'(p_ready), 32'd0);
        @(negedge clk);
        check("p_wr_ready_T1", 32'(p_ready), 32'd1);
        p_bus_enable = 1'b1; p_write_enable = 1'b0;
        @(negedge clk);
        p_bus_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("p_rd1", p_data_out, 32'hde00be00);
        check("p_rd1_ready", 32'(p_ready), 32'd1);
        p_bus_enable = 1'b1; p_address = 3'd2;
        @(negedge clk);
        p_bus_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("p_rd2", p_data_out, 32'h00000000);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
